dmem_line_bridge: RTL
=====================

Name: dmem_line_bridge

Overview:
Memory-side neighbour of the MEM stage. Consumes the 128-bit line request (cs/we/addr/wdata) issued by the data cache and the AES path. Serialises it into four 32-bit beats on a single-outstanding req/gnt/rvalid system bus, reassembles read beats into a 128-bit line, and returns a one-cycle rvalid plus the line to the cache. A per-beat watchdog terminates hung transfers with an error flag.

Parameters:
TIMEOUT, 256, max cycles per beat (from entering REQ to bus_rvalid_i) before abort; 0 disables watchdog
BEATS, 4, 32-bit beats per line; fixed at 4, any other value is unsupported

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
cs_i  input  1  line request valid from MEM stage; held until rvalid_o
we_i  input  1  1 = write line, 0 = read line
addr_i  input  32  line address; bits [3:0] ignored
wdata_i  input  128  write line; [31:0] goes to offset 0x0
rdata_o  output  128  assembled read line; [31:0] from offset 0x0
rvalid_o  output  1  one-cycle completion pulse (read or write)
err_o  output  1  valid with rvalid_o; 1 = watchdog abort
busy_o  output  1  state != IDLE
bus_req_o  output  1  beat request
bus_we_o  output  1  beat write enable
bus_addr_o  output  32  beat address
bus_wdata_o  output  32  beat write data
bus_gnt_i  input  1  beat accepted (sampled while bus_req_o=1)
bus_rvalid_i  input  1  beat response/ack, earliest one cycle after gnt
bus_rdata_i  input  32  beat read data, valid with bus_rvalid_i

Behaviour:
- Reset (async): state IDLE; rdata_o=0, rvalid_o=0, err_o=0, busy_o=0, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0; beat counter, timer, error flag and line buffers cleared. Reset mid-transfer drops bus_req_o immediately; no completion is signalled.
- FSM states IDLE, REQ, WAIT, RESP.
- IDLE: if cs_i: latch {addr_i[31:4],4'b0}, we_i, wdata_i; clear read buffer to 0; cnt=0; timer=0; err=0; go REQ. addr/we/wdata changes after acceptance are ignored.
- REQ: bus_req_o=1, bus_we_o=latched we, bus_addr_o={line[31:4],cnt[1:0],2'b00}, bus_wdata_o=wdata lane cnt (bits 32*cnt+31:32*cnt). Outputs stable until gnt. On bus_gnt_i go WAIT (bus_req_o=0 next cycle). bus_rvalid_i ignored in REQ.
- WAIT: bus_req_o=0. On bus_rvalid_i: if read, store bus_rdata_i into lane cnt; if cnt==3 go RESP, else cnt++, timer=0, go REQ.
- Watchdog: timer increments each cycle in REQ and WAIT, reset to 0 at each beat start. If TIMEOUT!=0 and timer==TIMEOUT-1 with no gnt (REQ) or no bus_rvalid_i (WAIT) that cycle: err=1, go RESP; remaining beats not issued; unreceived lanes stay 0. An rvalid arriving in the same cycle as the timeout wins (beat completes normally). A late bus_rvalid_i after abort is ignored in any state other than WAIT.
- RESP: rvalid_o=1 and err_o=err for exactly one cycle; rdata_o=read buffer (0 for writes); go IDLE.
- rdata_o holds its value until the next request is accepted (cleared on acceptance).
- Requester must drop cs_i in the cycle after rvalid_o. cs_i still high in IDLE is a new request (back-to-back allowed: minimum 1 idle cycle between rvalid_o and next bus_req_o).
- Latency, zero-wait bus (gnt same cycle as req, rvalid next cycle): cs_i accepted cycle 0, beats take 2 cycles each, rvalid_o in cycle 9.
- Timer width $clog2(TIMEOUT+1), minimum 1 bit.

Test Plan:
- Read, zero-wait bus, cs_i with addr=0x0000_1234 -> bus_addr_o 0x1230,0x1234,0x1238,0x123C; rdata beats 0x11111111..0x44444444 -> rdata_o=0x44444444_33333333_22222222_11111111, rvalid_o one cycle at cycle 9, err_o=0.
- Write, gnt delayed 3 cycles per beat, wdata_i=0xDDDD_CCCC_BBBB_AAAA_... lanes -> bus_wdata_o lane 0..3 in order with bus_we_o=1, outputs stable while req awaits gnt, single rvalid_o, rdata_o=0.
- Watchdog, TIMEOUT=8, no bus_rvalid_i on beat 2 -> rvalid_o with err_o=1 eight cycles after beat-2 start; rdata_o lanes 0,1 filled, lanes 2,3 = 0; beat 3 never requested.
- Timeout/rvalid collision: rvalid on exact timeout cycle -> beat accepted, transfer continues, err_o=0.
- Back-to-back: cs_i held high after rvalid_o -> second read starts, bus_req_o asserts 2 cycles after rvalid_o, rdata_o cleared on acceptance.
- Reset asserted in WAIT of beat 1 -> all outputs 0 asynchronously, no rvalid_o; fresh request after release completes normally.

Source files
------------

// File: rtl/dmem_line_bridge.sv
// dmem_line_bridge
// Takes a 128-bit line request from the MEM stage and splits it into four
// 32-bit beats on a single-outstanding req/gnt/rvalid system bus. Read beats
// are gathered back into one line, and a single-cycle rvalid_o reports the
// end of the transfer. A per-beat watchdog ends a hung transfer and raises
// err_o together with rvalid_o.

module dmem_line_bridge #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned BEATS   = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cs_i,
  input  logic          we_i,
  input  logic [31:0]   addr_i,
  input  logic [127:0]  wdata_i,
  output logic [127:0]  rdata_o,
  output logic          rvalid_o,
  output logic          err_o,
  output logic          busy_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [31:0]   bus_addr_o,
  output logic [31:0]   bus_wdata_o,
  input  logic          bus_gnt_i,
  input  logic          bus_rvalid_i,
  input  logic [31:0]   bus_rdata_i
);

  // The timer counts from 0 to TIMEOUT-1 inside one beat. It is always at
  // least one bit wide so that TIMEOUT = 0 (watchdog disabled) still builds.
  localparam int unsigned TW = (TIMEOUT == 32'd0) ? 32'd1 : $clog2(TIMEOUT + 32'd1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(32'd1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 32'd1);
  localparam logic [1:0]    LAST_BEAT = 2'(BEATS - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Picks one 32-bit lane out of a line. Lane 0 is the lowest address.
  function automatic logic [31:0] lane_sel(input logic [127:0] line, input logic [1:0] idx);
    logic [31:0] lane;
    case (idx)
      2'd0:    lane = line[31:0];
      2'd1:    lane = line[63:32];
      2'd2:    lane = line[95:64];
      2'd3:    lane = line[127:96];
      default: lane = line[31:0];
    endcase
    return lane;
  endfunction

  // Replaces one 32-bit lane of a line and leaves the other lanes unchanged.
  function automatic logic [127:0] lane_put(input logic [127:0] line, input logic [1:0] idx,
                                            input logic [31:0] lane);
    logic [127:0] res;
    res = line;
    case (idx)
      2'd0:    res[31:0]   = lane;
      2'd1:    res[63:32]  = lane;
      2'd2:    res[95:64]  = lane;
      2'd3:    res[127:96] = lane;
      default: res         = line;
    endcase
    return res;
  endfunction

  state_e         state_r;
  logic [27:0]    line_addr_r;
  logic           we_r;
  logic [127:0]   wdata_r;
  logic [127:0]   rbuf_r;
  logic [1:0]     cnt_r;
  logic [TW-1:0]  timer_r;
  logic           err_r;

  logic [1:0]     cnt_next_s;
  logic           timeout_s;
  logic [127:0]   rbuf_next_s;
  logic [3:0]     addr_lo_unused_s;

  // Line offset bits are not used. The whole line is always transferred.
  assign addr_lo_unused_s = addr_i[3:0];

  assign cnt_next_s = cnt_r + 2'd1;

  // The abort check uses >= so that a counter that has gone past the limit
  // still aborts. Normally the counter never gets past TIMER_MAX.
  assign timeout_s = (TIMEOUT != 32'd0) && (timer_r >= TIMER_MAX);

  // Read buffer after this cycle's beat data has been merged in. The RESP
  // outputs use this value so that the last beat is part of rdata_o.
  always_comb begin
    rbuf_next_s = rbuf_r;
    if ((state_r == ST_WAIT) && bus_rvalid_i && !we_r) begin
      rbuf_next_s = lane_put(rbuf_r, cnt_r, bus_rdata_i);
    end else begin
      rbuf_next_s = rbuf_r;
    end
  end

  // Main FSM. It also drives the registered bus outputs and requester outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      line_addr_r <= 28'd0;
      we_r        <= 1'b0;
      wdata_r     <= 128'd0;
      rbuf_r      <= 128'd0;
      cnt_r       <= 2'd0;
      timer_r     <= '0;
      err_r       <= 1'b0;
      rdata_o     <= 128'd0;
      rvalid_o    <= 1'b0;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'd0;
      bus_wdata_o <= 32'd0;
    end else begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cs_i) begin
            line_addr_r <= addr_i[31:4];
            we_r        <= we_i;
            wdata_r     <= wdata_i;
            rbuf_r      <= 128'd0;
            rdata_o     <= 128'd0;
            cnt_r       <= 2'd0;
            timer_r     <= '0;
            err_r       <= 1'b0;
            busy_o      <= 1'b1;
            bus_req_o   <= 1'b1;
            bus_we_o    <= we_i;
            bus_addr_o  <= {addr_i[31:4], 4'h0};
            bus_wdata_o <= wdata_i[31:0];
            state_r     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            timer_r   <= timer_r + TIMER_ONE;
            state_r   <= ST_WAIT;
          end else if (timeout_s) begin
            bus_req_o <= 1'b0;
            err_r     <= 1'b1;
            rvalid_o  <= 1'b1;
            err_o     <= 1'b1;
            rdata_o   <= rbuf_next_s;
            state_r   <= ST_RESP;
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        ST_WAIT: begin
          if (bus_rvalid_i) begin
            rbuf_r <= rbuf_next_s;
            if (cnt_r == LAST_BEAT) begin
              rvalid_o <= 1'b1;
              err_o    <= err_r;
              rdata_o  <= rbuf_next_s;
              state_r  <= ST_RESP;
            end else begin
              cnt_r       <= cnt_next_s;
              timer_r     <= '0;
              bus_req_o   <= 1'b1;
              bus_addr_o  <= {line_addr_r, cnt_next_s, 2'b00};
              bus_wdata_o <= lane_sel(wdata_r, cnt_next_s);
              state_r     <= ST_REQ;
            end
          end else if (timeout_s) begin
            err_r    <= 1'b1;
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
            rdata_o  <= rbuf_next_s;
            state_r  <= ST_RESP;
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        ST_RESP: begin
          busy_o  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          bus_req_o <= 1'b0;
          busy_o    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
